// File: rtl/seg7_pkg.sv
// seg7_pkg: segment lookup and polarity helpers shared by the 7-segment scan display.
package seg7_pkg;
   localparam logic [6:0] SEG7_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   localparam logic [7:0] SEG_OFF = 8'h00;
   function automatic logic [7:0] seg7_polarity(input logic [7:0] value, input logic active_low);
      return active_low ? ~value : value;
   endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: hex nibble to active-high {g,f,e,d,c,b,a} segments.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = SEG7_HEX[nibble];
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed common-anode 7-segment scanner with frame-aligned double buffering.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int CLK_DIV        = 169344,
   parameter int DIGITS         = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data_in,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);
   localparam int CW = $clog2(CLK_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow_data, act_data;
   logic [DIGITS-1:0]   shadow_dp, act_dp, an_nx;
   logic [3:0]          nibble;
   logic [6:0]          seg_hex;
   logic [7:0]          an_pol, seg_pol, dp_pol;
   logic                tick, wrap, show;
   seg7_hex_decode u_dec (.nibble(nibble), .seg(seg_hex));
   always_comb begin
      tick    = en && cnt == CW'(CLK_DIV - 1);
      wrap    = tick && idx == IW'(DIGITS - 1);
      show    = en && !rst;
      nibble  = act_data[4*idx +: 4];
      an_nx   = show ? DIGITS'(1) << idx : '0;
      an_pol  = seg7_polarity(8'(an_nx), SEG_ACTIVE_LOW);
      seg_pol = seg7_polarity(show ? {1'b0, seg_hex} : SEG_OFF, SEG_ACTIVE_LOW);
      dp_pol  = seg7_polarity(8'(show && act_dp[idx]), SEG_ACTIVE_LOW);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         shadow_data <= '0;
         shadow_dp   <= '0;
         act_data    <= '0;
         act_dp      <= '0;
         frame_done  <= 1'b0;
      end else begin
         cnt        <= tick ? '0 : cnt + CW'(en);
         idx        <= wrap ? '0 : idx + IW'(tick);
         frame_done <= wrap;
         if (load) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
         end
         // A load coinciding with the wrap goes straight into the new frame.
         if (wrap) begin
            act_data <= load ? data_in : shadow_data;
            act_dp   <= load ? dp_in : shadow_dp;
         end
      end
      an  <= an_pol[DIGITS-1:0];
      seg <= seg_pol[6:0];
      dp  <= dp_pol[0];
   end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed checks of scan timing, buffering, enable hold and reset.
module tb_seg7_scan_display;
   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [15:0] data_in;
   logic [3:0]  dp_in, an;
   logic [6:0]  seg;
   logic        dp, frame_done;
   int          checks = 0;
   int          failures = 0;
   logic [6:0]  seg_zero [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
   logic [6:0]  seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
   logic [6:0]  seg_abcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
   logic        dp_zero  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic        dp_1234  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
   logic        dp_abcd  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
   seg7_scan_display #(.CLK_DIV(4), .DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .data_in(data_in), .dp_in(dp_in),
      .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk_off(input string tag);
      chk({tag, " an"}, 32'(an), 32'hF);
      chk({tag, " seg"}, 32'(seg), 32'h7F);
      chk({tag, " dp"}, 32'(dp), 32'd1);
      chk({tag, " fd"}, 32'(frame_done), 32'd0);
   endtask
   initial begin
      int d, f;
      logic [3:0] an_exp;
      logic [6:0] seg_exp;
      logic       dp_exp;
      rst = 1'b1; en = 1'b1; load = 1'b0; data_in = '0; dp_in = '0;
      repeat (3) step();
      chk_off("reset");
      rst = 1'b0;
      for (int e = 1; e <= 80; e++) begin
         step();
         d = ((e - 1) % 16) / 4;
         f = (e - 1) / 16;
         an_exp  = 4'hF ^ (4'b1 << d);
         seg_exp = f == 0 ? seg_zero[d] : f < 3 ? seg_1234[d] : seg_abcd[d];
         dp_exp  = f == 0 ? dp_zero[d]  : f < 3 ? dp_1234[d]  : dp_abcd[d];
         chk($sformatf("scan e%0d an", e), 32'(an), 32'(an_exp));
         chk($sformatf("scan e%0d seg", e), 32'(seg), 32'(seg_exp));
         chk($sformatf("scan e%0d dp", e), 32'(dp), 32'(dp_exp));
         chk($sformatf("scan e%0d fd", e), 32'(frame_done), 32'(e % 16 == 0));
         load = 1'b0;
         if (e == 5) begin
            load = 1'b1; data_in = 16'h1234; dp_in = 4'b0001;
         end
         if (e == 47) begin
            load = 1'b1; data_in = 16'hABCD; dp_in = 4'b1000;
         end
      end
      repeat (9) step();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_off($sformatf("hold %0d", i));
      end
      en = 1'b1;
      step();
      chk("resume an", 32'(an), 32'hB);
      chk("resume seg", 32'(seg), 32'h03);
      step();
      chk("resume an+1", 32'(an), 32'hB);
      step();
      chk("resume an+2", 32'(an), 32'hB);
      step();
      chk("resume an+3", 32'(an), 32'h7);
      chk("resume seg+3", 32'(seg), 32'h08);
      rst = 1'b1; load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
      step();
      chk_off("midreset");
      rst = 1'b0; load = 1'b0;
      for (int r = 1; r <= 20; r++) begin
         step();
         d = ((r - 1) % 16) / 4;
         chk($sformatf("post r%0d an", r), 32'(an), 32'(4'hF ^ (4'b1 << d)));
         chk($sformatf("post r%0d seg", r), 32'(seg), 32'h40);
         chk($sformatf("post r%0d dp", r), 32'(dp), 32'd1);
         chk($sformatf("post r%0d fd", r), 32'(frame_done), 32'(r == 16));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
